piso_serializer: RTL and testbench

- Parallel-in/serial-out stage that sits directly upstream of the SISO shift-register chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives one bit per clock on sout, which feeds the chain's serial d input.
- Marks each frame's first bit and supports gapless back-to-back words.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_bit_counter.sv | 33 +++
 rtl/piso_serializer.sv | 138 +++++++++++++
 tb/tb_piso_serializer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Optional build macro: PISO_PARITY_EN (appends an even-parity bit to each frame).
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  // Counter width able to hold every bit index of a frame, including a parity slot.
  function automatic int piso_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared on load, advances once per shifted bit, and
// saturates on the last bit of the frame (index L-1) instead of wrapping.
import piso_pkg::*;

module piso_bit_counter #(
  parameter int L     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(L - 1));
  assign o_cnt  = r_cnt;
  assign o_last = w_last;

  // Bit index register: restart on a new word, step while bits remain.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_inc && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the SISO shift-register chain.
// Accepts a WIDTH-bit word over valid/ready and emits one bit per clock,
// flagging the first bit of each frame; back-to-back words run gapless.
// Optional build macro: PISO_PARITY_EN (frame gains a trailing even-parity bit).
import piso_pkg::*;

module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CNT_W = piso_cnt_w(WIDTH);

  piso_state_t      r_state;
  piso_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic             r_sout;
  logic             r_valid;
  logic             r_first;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_last;
  logic             w_last_bit;
  logic             w_accept;
  logic             w_ready;
  logic             w_first_bit;
  logic             w_next_bit;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  assign w_last_bit = (r_state == SHIFT) && w_cnt_last;
  assign w_accept   = din_valid && w_ready;
  assign w_first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];

  assign din_ready  = w_ready;
  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign sout_first = r_first;
  assign busy       = (r_state == SHIFT);

  piso_bit_counter #(
    .L     (L),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_inc  (r_state == SHIFT),
    .o_cnt  (w_cnt),
    .o_last (w_cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake: ready when idle or while the last bit is on sout.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = !rst;
        if (din_valid && !rst) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_ready = !rst && w_cnt_last;
        if (w_cnt_last && !(din_valid && !rst)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift direction and the bit that follows the one currently on sout.
  always_comb begin
    if (MSB_FIRST != 0) begin
      w_shifted  = {r_shreg[WIDTH-2:0], 1'b0};
      w_next_bit = r_shreg[WIDTH-2];
    end else begin
      w_shifted  = {1'b0, r_shreg[WIDTH-1:1]};
      w_next_bit = r_shreg[1];
    end
`ifdef PISO_PARITY_EN
    if (w_cnt == CNT_W'(WIDTH - 1)) w_next_bit = r_par;
`endif
  end

`ifdef PISO_PARITY_EN
  // Even parity of the accepted word, driven after the last data bit.
  always_ff @(posedge clk) begin
    if (rst)           r_par <= 1'b0;
    else if (w_accept) r_par <= ^din;
  end
`endif

  // Shift register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
    end else if (w_accept) begin
      r_shreg <= din;
      r_sout  <= w_first_bit;
      r_valid <= 1'b1;
      r_first <= 1'b1;
    end else if (r_state == SHIFT) begin
      r_first <= 1'b0;
      if (!w_last_bit) begin
        r_shreg <= w_shifted;
        r_sout  <= w_next_bit;
      end else begin
        r_valid <= 1'b0;
        r_sout  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first and LSB-first) share the
// same input stream; a frame-queue reference model predicts every output.
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;

  logic rdy_m, sout_m, vld_m, fst_m, busy_m;
  logic rdy_l, sout_l, vld_l, fst_l, busy_l;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: bits of the current frame still waiting to appear on sout.
  logic q_m[$];
  logic q_l[$];
  logic e_sout_m, e_sout_l, e_vld, e_fst;
  logic [15:0] obs;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(vld_m),
    .sout_first(fst_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(vld_l),
    .sout_first(fst_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    rst = r; din_valid = v; din = d;
    #1;
    exp_rdy = !r && (q_m.size() == 0);
    check("din_ready_msb", {31'd0, rdy_m}, {31'd0, exp_rdy});
    check("din_ready_lsb", {31'd0, rdy_l}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    if (r) begin
      q_m.delete(); q_l.delete();
      e_vld = 0; e_fst = 0; e_sout_m = 0; e_sout_l = 0;
    end else if (acc) begin
      q_m.delete(); q_l.delete();
      for (int i = 0; i < WIDTH; i++) begin
        q_m.push_back(d[WIDTH-1-i]);
        q_l.push_back(d[i]);
      end
`ifdef PISO_PARITY_EN
      q_m.push_back(^d);
      q_l.push_back(^d);
`endif
      e_sout_m = q_m.pop_front();
      e_sout_l = q_l.pop_front();
      e_vld = 1; e_fst = 1;
    end else if (q_m.size() != 0) begin
      e_sout_m = q_m.pop_front();
      e_sout_l = q_l.pop_front();
      e_vld = 1; e_fst = 0;
    end else begin
      e_vld = 0; e_fst = 0; e_sout_m = 0; e_sout_l = 0;
    end
    @(posedge clk);
    #1;
    obs = {obs[14:0], sout_m};
    check("sout_msb",       {31'd0, sout_m}, {31'd0, e_sout_m});
    check("sout_lsb",       {31'd0, sout_l}, {31'd0, e_sout_l});
    check("sout_valid_msb", {31'd0, vld_m},  {31'd0, e_vld});
    check("sout_valid_lsb", {31'd0, vld_l},  {31'd0, e_vld});
    check("sout_first_msb", {31'd0, fst_m},  {31'd0, e_fst});
    check("sout_first_lsb", {31'd0, fst_l},  {31'd0, e_fst});
    check("busy_msb",       {31'd0, busy_m}, {31'd0, e_vld});
    check("busy_lsb",       {31'd0, busy_l}, {31'd0, e_vld});
  endtask

  // Idle steps until the model frame drains, then one more idle cycle.
  task automatic drain();
    logic a;
    for (int i = 0; i < 12 && q_m.size() != 0; i++) step(1'b0, 1'b0, '0, a);
    check("drain_bound", {31'd0, q_m.size() == 0}, 32'd1);
    step(1'b0, 1'b0, '0, a);
  endtask

  initial begin
    logic a;
    logic hold;
    logic r, v;
    logic [WIDTH-1:0] d;
    int   k;
    e_sout_m = 0; e_sout_l = 0; e_vld = 0; e_fst = 0; obs = '0;

    // Reset held with a valid word present: nothing may be accepted.
    step(1'b1, 1'b1, 8'hFF, a);
    step(1'b1, 1'b1, 8'hFF, a);
    step(1'b0, 1'b0, 8'hFF, a);

    // Single word A5, MSB first: the eight collected bits rebuild the word.
    step(1'b0, 1'b1, 8'hA5, a);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, a);
    check("a5_serial_bits", {24'd0, obs[7:0]}, 32'h0000_00A5);
    drain();

    // Back-to-back F0 then 0F with valid held high.
    step(1'b0, 1'b1, 8'hF0, a);
    k = 0;
    do begin
      step(1'b0, 1'b1, 8'h0F, a);
      k++;
    end while (!a && k < 20);
    check("b2b_accept", {31'd0, a}, 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, a);
`ifndef PISO_PARITY_EN
    check("b2b_serial_bits", {16'd0, obs}, 32'h0000_F00F);
`endif
    drain();

    // Word 01: LSB-first instance emits 1 then zeros.
    step(1'b0, 1'b1, 8'h01, a);
    drain();

    // Mid-frame reset after three bits.
    step(1'b0, 1'b1, 8'hA5, a);
    step(1'b0, 1'b0, '0, a);
    step(1'b0, 1'b0, '0, a);
    step(1'b1, 1'b0, '0, a);
    step(1'b0, 1'b0, '0, a);
    step(1'b0, 1'b0, '0, a);

    // Randomized traffic; upstream holds a word until it is accepted.
    hold = 0; d = '0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 60) == 0);
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
      end else begin
        v = 1'b1;
      end
      step(r, v, d, a);
      hold = v && !a && !r;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
